// File: rtl/alu_req_seq.sv
// Request/response sequencer in front of a combinational 32-bit ALU: registers
// operands, holds them for ALU_LAT cycles, then returns the sampled result with its tag.
module alu_req_seq #(
   parameter int unsigned TAG_W   = 4,
   parameter int unsigned ALU_LAT = 1,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [31:0]      req_a,
   input  logic [31:0]      req_b,
   input  logic [31:0]      req_instr,
   input  logic [TAG_W-1:0] req_tag,
   output logic [31:0]      alu_a,
   output logic [31:0]      alu_b,
   output logic [31:0]      alu_instr,
   input  logic [31:0]      alu_s,
   input  logic             alu_ze,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_s,
   output logic             rsp_ze,
   output logic [TAG_W-1:0] rsp_tag,
   output logic             busy,
   output logic [CNT_W-1:0] op_count
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned WAIT_W = 4;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [DATA_W-1:0] alu_a_q, alu_a_d;
   logic [DATA_W-1:0] alu_b_q, alu_b_d;
   logic [DATA_W-1:0] alu_instr_q, alu_instr_d;
   logic [TAG_W-1:0]  tag_q, tag_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_s_q, rsp_s_d;
   logic              rsp_ze_q, rsp_ze_d;
   logic [TAG_W-1:0]  rsp_tag_q, rsp_tag_d;
   logic [CNT_W-1:0]  op_count_q, op_count_d;

   // Next-state and datapath update; every register holds unless its state says otherwise.
   always_comb begin
      state_d     = state_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_instr_d = alu_instr_q;
      tag_d       = tag_q;
      wait_d      = wait_q;
      rsp_valid_d = rsp_valid_q;
      rsp_s_d     = rsp_s_q;
      rsp_ze_d    = rsp_ze_q;
      rsp_tag_d   = rsp_tag_q;
      op_count_d  = op_count_q;

      unique case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               alu_a_d     = req_a;
               alu_b_d     = req_b;
               alu_instr_d = req_instr;
               tag_d       = req_tag;
               wait_d      = WAIT_W'(ALU_LAT - 1);
               state_d     = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (wait_q != WAIT_W'(0)) begin
               wait_d = wait_q - WAIT_W'(1);
            end else begin
               rsp_s_d     = alu_s;
               rsp_ze_d    = alu_ze;
               rsp_tag_d   = tag_q;
               rsp_valid_d = 1'b1;
               state_d     = ST_RESP;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               op_count_d  = op_count_q + CNT_W'(1);
               state_d     = ST_IDLE;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            rsp_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_instr_q <= '0;
         tag_q       <= '0;
         wait_q      <= '0;
         rsp_valid_q <= 1'b0;
         rsp_s_q     <= '0;
         rsp_ze_q    <= 1'b0;
         rsp_tag_q   <= '0;
         op_count_q  <= '0;
      end else begin
         state_q     <= state_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_instr_q <= alu_instr_d;
         tag_q       <= tag_d;
         wait_q      <= wait_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_s_q     <= rsp_s_d;
         rsp_ze_q    <= rsp_ze_d;
         rsp_tag_q   <= rsp_tag_d;
         op_count_q  <= op_count_d;
      end
   end

   // Handshake readiness and busy are pure decodes of the state register.
   assign req_ready = (state_q == ST_IDLE);
   assign busy      = (state_q != ST_IDLE);

   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign alu_instr = alu_instr_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_s     = rsp_s_q;
   assign rsp_ze    = rsp_ze_q;
   assign rsp_tag   = rsp_tag_q;
   assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_req_seq.sv
// Bench for alu_req_seq: instance 0 (ALU_LAT=1, CNT_W=16, adder stub) and
// instance 1 (ALU_LAT=3, CNT_W=2, stub output drifting every cycle).
module tb_alu_req_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        rst       [2];
   logic        req_valid [2];
   logic        req_ready [2];
   logic [31:0] req_a     [2];
   logic [31:0] req_b     [2];
   logic [31:0] req_instr [2];
   logic [3:0]  req_tag   [2];
   logic [31:0] alu_a     [2];
   logic [31:0] alu_b     [2];
   logic [31:0] alu_instr [2];
   logic [31:0] alu_s     [2];
   logic        alu_ze    [2];
   logic        rsp_valid [2];
   logic        rsp_ready [2];
   logic [31:0] rsp_s     [2];
   logic        rsp_ze    [2];
   logic [3:0]  rsp_tag   [2];
   logic        busy      [2];
   logic [15:0] op_count0;
   logic [1:0]  op_count1;

   // ALU stubs: plain adder, and an adder whose output moves every cycle
   assign alu_s[0]  = alu_a[0] + alu_b[0];
   assign alu_s[1]  = alu_a[1] + alu_b[1] + cyc;
   assign alu_ze[0] = (alu_s[0] == 32'd0);
   assign alu_ze[1] = (alu_s[1] == 32'd0);

   alu_req_seq #(.TAG_W(4), .ALU_LAT(1), .CNT_W(16)) u_dut0 (
      .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_a(req_a[0]), .req_b(req_b[0]), .req_instr(req_instr[0]), .req_tag(req_tag[0]),
      .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_instr(alu_instr[0]),
      .alu_s(alu_s[0]), .alu_ze(alu_ze[0]),
      .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_s(rsp_s[0]),
      .rsp_ze(rsp_ze[0]), .rsp_tag(rsp_tag[0]), .busy(busy[0]), .op_count(op_count0)
   );

   alu_req_seq #(.TAG_W(4), .ALU_LAT(3), .CNT_W(2)) u_dut1 (
      .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_a(req_a[1]), .req_b(req_b[1]), .req_instr(req_instr[1]), .req_tag(req_tag[1]),
      .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_instr(alu_instr[1]),
      .alu_s(alu_s[1]), .alu_ze(alu_ze[1]),
      .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_s(rsp_s[1]),
      .rsp_ze(rsp_ze[1]), .rsp_tag(rsp_tag[1]), .busy(busy[1]), .op_count(op_count1)
   );

   int          checks = 0;
   int          errors = 0;
   logic [63:0] cnt_exp [2];

   function automatic int lat(input int d);
      return (d == 1) ? 3 : 1;
   endfunction

   function automatic logic [63:0] cmask(input int d);
      return (d == 1) ? 64'h3 : 64'hFFFF;
   endfunction

   function automatic logic [63:0] get_cnt(input int d);
      return (d == 1) ? 64'(op_count1) : 64'(op_count0);
   endfunction

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle_zero(input int d);
      chk("rz_rsp_valid", 64'(rsp_valid[d]), 0);
      chk("rz_req_ready", 64'(req_ready[d]), 1);
      chk("rz_busy",      64'(busy[d]), 0);
      chk("rz_alu_a",     64'(alu_a[d]), 0);
      chk("rz_alu_b",     64'(alu_b[d]), 0);
      chk("rz_alu_instr", 64'(alu_instr[d]), 0);
      chk("rz_rsp_s",     64'(rsp_s[d]), 0);
      chk("rz_rsp_ze",    64'(rsp_ze[d]), 0);
      chk("rz_rsp_tag",   64'(rsp_tag[d]), 0);
      chk("rz_op_count",  get_cnt(d), 0);
   endtask

   // One full transaction; the reference result is a+b plus, for the drifting stub,
   // the stub offset in force during the last EXEC cycle.
   task automatic run_op(input int d, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] instr, input logic [3:0] tag, input int bp);
      logic [31:0] exp_s;
      int          n;
      req_valid[d] = 1'b1; req_a[d] = a; req_b[d] = b; req_instr[d] = instr; req_tag[d] = tag;
      rsp_ready[d] = (bp == 0);
      chk("idle_req_ready", 64'(req_ready[d]), 1);
      tick();
      exp_s = a + b + ((d == 1) ? (cyc + 32'(lat(d) - 1)) : 32'd0);
      req_a[d] = $urandom; req_b[d] = $urandom; req_instr[d] = $urandom; req_tag[d] = ~tag;
      n = 0;
      while (rsp_valid[d] !== 1'b1 && n < 20) begin
         chk("exec_req_ready", 64'(req_ready[d]), 0);
         chk("exec_busy",      64'(busy[d]), 1);
         chk("exec_alu_a",     64'(alu_a[d]), 64'(a));
         chk("exec_alu_b",     64'(alu_b[d]), 64'(b));
         chk("exec_alu_instr", 64'(alu_instr[d]), 64'(instr));
         tick();
         n++;
      end
      chk("latency", 64'(n), 64'(lat(d)));
      chk("rsp_s",   64'(rsp_s[d]), 64'(exp_s));
      chk("rsp_ze",  64'(rsp_ze[d]), 64'(exp_s == 32'd0));
      chk("rsp_tag", 64'(rsp_tag[d]), 64'(tag));
      for (int i = 0; i < bp; i++) begin
         tick();
         chk("bp_rsp_valid", 64'(rsp_valid[d]), 1);
         chk("bp_req_ready", 64'(req_ready[d]), 0);
         chk("bp_rsp_s",     64'(rsp_s[d]), 64'(exp_s));
         chk("bp_rsp_ze",    64'(rsp_ze[d]), 64'(exp_s == 32'd0));
         chk("bp_rsp_tag",   64'(rsp_tag[d]), 64'(tag));
      end
      rsp_ready[d] = 1'b1;
      req_valid[d] = 1'b0;
      tick();
      rsp_ready[d] = 1'b0;
      cnt_exp[d] = (cnt_exp[d] + 1) & cmask(d);
      chk("done_rsp_valid", 64'(rsp_valid[d]), 0);
      chk("done_op_count",  get_cnt(d), cnt_exp[d]);
      chk("done_req_ready", 64'(req_ready[d]), 1);
      chk("done_busy",      64'(busy[d]), 0);
      chk("done_alu_a_kept", 64'(alu_a[d]), 64'(a));
   endtask

   // Abort a transaction on instance 0 with a one-cycle reset, in EXEC or in RESP.
   task automatic reset_mid_op(input bit in_resp);
      req_valid[0] = 1'b1; req_a[0] = 32'h1234; req_b[0] = 32'h1; req_instr[0] = 32'h7;
      req_tag[0] = 4'h9; rsp_ready[0] = 1'b0;
      tick();
      req_valid[0] = 1'b0;
      if (in_resp) begin
         tick();
         chk("rmid_in_resp", 64'(rsp_valid[0]), 1);
      end else begin
         chk("rmid_in_exec", 64'(busy[0]), 1);
      end
      rst[0] = 1'b1;
      tick();
      rst[0] = 1'b0;
      rsp_ready[0] = 1'b1;
      chk_idle_zero(0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("rmid_no_rsp", 64'(rsp_valid[0]), 0);
      end
      rsp_ready[0] = 1'b0;
   endtask

   // Four requests with req_valid held high; accepts must be 3 cycles apart, in order.
   task automatic back_to_back();
      logic [35:0] q[$];
      logic [35:0] e;
      logic [31:0] a, b;
      int acc = 0, got = 0, last = 0;
      bit acc_now;
      rsp_ready[0] = 1'b1;
      a = $urandom; b = $urandom;
      req_valid[0] = 1'b1; req_a[0] = a; req_b[0] = b; req_instr[0] = 32'h3; req_tag[0] = 4'd0;
      for (int k = 0; k < 60 && got < 4; k++) begin
         acc_now = 1'b0;
         if (rsp_valid[0] === 1'b1) begin
            if (q.size() == 0) begin
               chk("b2b_extra_rsp", 64'(rsp_valid[0]), 0);
            end else begin
               e = q.pop_front();
               chk("b2b_tag", 64'(rsp_tag[0]), 64'(e[35:32]));
               chk("b2b_s",   64'(rsp_s[0]), 64'(e[31:0]));
            end
            got++;
         end
         if (req_ready[0] === 1'b1 && req_valid[0] === 1'b1) begin
            if (acc > 0) chk("b2b_spacing", 64'(k - last), 3);
            last = k;
            q.push_back({req_tag[0], req_a[0] + req_b[0]});
            acc++;
            acc_now = 1'b1;
         end
         tick();
         if (acc_now) begin
            if (acc == 4) begin
               req_valid[0] = 1'b0;
            end else begin
               a = $urandom; b = $urandom;
               req_a[0] = a; req_b[0] = b; req_tag[0] = 4'(acc);
            end
         end
      end
      chk("b2b_got", 64'(got), 4);
      chk("b2b_acc", 64'(acc), 4);
      for (int i = 0; i < 4; i++) begin
         chk("b2b_quiet", 64'(rsp_valid[0]), 0);
         tick();
      end
      cnt_exp[0] = (cnt_exp[0] + 4) & cmask(0);
      chk("b2b_op_count", get_cnt(0), cnt_exp[0]);
      rsp_ready[0] = 1'b0;
   endtask

   task automatic random_ops(input int d, input int cnt);
      logic [31:0] a, b;
      for (int i = 0; i < cnt; i++) begin
         a = $urandom;
         b = ($urandom_range(0, 3) == 0) ? (32'd0 - a) : 32'($urandom);
         run_op(d, a, b, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3));
      end
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b1; req_valid[d] = 1'b1; req_a[d] = 32'hDEAD; req_b[d] = 32'hBEEF;
         req_instr[d] = 32'h1; req_tag[d] = 4'hF; rsp_ready[d] = 1'b0; cnt_exp[d] = 0;
      end
      repeat (3) tick();
      for (int d = 0; d < 2; d++) begin
         chk_idle_zero(d);
         rst[d] = 1'b0; req_valid[d] = 1'b0;
      end

      reset_mid_op(1'b0);
      reset_mid_op(1'b1);
      run_op(0, 32'hFFFF_FFFB, 32'hFFFF_FFFE, 32'h10, 4'd3, 0);
      chk("basic_count", get_cnt(0), 1);
      run_op(0, 32'h5, 32'hFFFF_FFFB, 32'h11, 4'd5, 0);
      run_op(0, 32'h0001_0000, 32'h0000_00FF, 32'h12, 4'd7, 10);
      back_to_back();
      random_ops(0, 8);

      // slow ALU and 2-bit counter: five ops walk op_count through 1,2,3,0,1
      for (int i = 0; i < 5; i++) begin
         run_op(1, $urandom, $urandom, 32'h20 + 32'(i), 4'(i), (i == 2) ? 4 : 0);
      end
      chk("wrap_final", get_cnt(1), 1);
      random_ops(1, 8);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/alu_req_seq.md
Name: alu_req_seq

Overview:
- Sequential requester/driver front-end for the combinational 32-bit ALU (ports s, ze, a, b, instruction; opcode in instruction[4:0]).
- Accepts operations over a valid/ready request channel, drives the registered operands and instruction into the ALU, and waits a fixed settle time.
- Captures result s and zero flag ze, and returns them with a tag over a valid/ready response channel.
- Sits between the decode/issue logic and the ALU; it is the initiating end of the ALU operand/result interface.

Parameters:
- TAG_W, 4, width of request/response tag.
- ALU_LAT, 1, cycles the ALU inputs are held before the result is sampled (legal range 1..15).
- CNT_W, 16, width of completed-operation counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_a  input  32  operand a.
- req_b  input  32  operand b.
- req_instr  input  32  instruction word passed to the ALU unmodified.
- req_tag  input  TAG_W  tag returned with the result.
- alu_a  output  32  registered operand to ALU a.
- alu_b  output  32  registered operand to ALU b.
- alu_instr  output  32  registered instruction to ALU.
- alu_s  input  32  ALU result.
- alu_ze  input  1  ALU zero flag.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts response.
- rsp_s  output  32  captured result.
- rsp_ze  output  1  captured zero flag.
- rsp_tag  output  TAG_W  tag of the completed request.
- busy  output  1  high in EXEC or RESP.
- op_count  output  CNT_W  number of completed response handshakes.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state becomes IDLE.
  - alu_a, alu_b, alu_instr, rsp_s, rsp_ze, rsp_tag, op_count all become 0.
  - rsp_valid=0, busy=0, internal wait counter=0.
  - rst takes priority over every other event.
  - A reset mid-operation (EXEC or RESP) discards the transaction; no response is ever produced for it.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready at an edge: load alu_a/alu_b/alu_instr from req_a/req_b/req_instr, latch req_tag, set wait counter=ALU_LAT-1, go to EXEC.
- EXEC:
  - req_ready=0; alu_* held stable.
  - If wait counter≠0: decrement it and stay in EXEC.
  - If wait counter=0 at the edge: rsp_s<=alu_s, rsp_ze<=alu_ze, rsp_tag<=latched tag, rsp_valid<=1, go to RESP.
  - EXEC therefore lasts exactly ALU_LAT cycles.
- RESP:
  - req_ready=0; rsp_valid=1.
  - rsp_s, rsp_ze and rsp_tag are held stable while rsp_ready=0 (backpressure is unbounded).
  - On rsp_valid&&rsp_ready at an edge: rsp_valid<=0, op_count<=op_count+1, go to IDLE.
  - op_count wraps from 2^CNT_W-1 to 0.
- req_ready is combinational from state only (IDLE); it never depends on req_valid. rsp_valid is registered.
- alu_* keep the last operands after completion until the next accept; there is no zeroing between operations.
- Latency: request accepted at edge E → rsp_valid high after edge E+ALU_LAT.
- Minimum spacing between accepts: ALU_LAT+2 cycles when rsp_ready is tied high.
- busy = (state≠IDLE).
- Request signals are ignored outside IDLE; req_valid held high during EXEC/RESP is not accepted twice.
- The opcode is not interpreted; all widths pass through at 32 bits with no sign or zero extension.

Test Plan:
- Basic op: ALU_LAT=1, bench ALU stub s=a+b, ze=(s==0); send a=0xFFFFFFFB (-5), b=0xFFFFFFFE (-2), instr=0x10, tag=3 with rsp_ready=1 → rsp_valid high exactly 1 cycle after accept, rsp_s=0xFFFFFFF9, rsp_ze=0, rsp_tag=3, op_count=1.
- Zero flag: a=5, b=0xFFFFFFFB → rsp_s=0, rsp_ze=1.
- Backpressure: hold rsp_ready=0 for 10 cycles → rsp_valid stays 1, rsp_s/rsp_ze/rsp_tag stable, req_ready=0 throughout; raise rsp_ready → one handshake, op_count +1, req_ready=1 next cycle.
- Latency parameter: ALU_LAT=3 with a stub that changes alu_s every cycle → sampled value equals the stub output on the 3rd EXEC cycle; rsp_valid rises 3 cycles after accept.
- Back-to-back stream: req_valid held high with 4 requests (tags 0..3), rsp_ready=1, ALU_LAT=1 → accepts every 3 cycles, responses in order with tags 0..3, op_count=4, no duplicate accepts.
- Reset mid-op: assert rst for 1 cycle during EXEC, then during RESP → no response emitted, all outputs 0, op_count unchanged at 0, next request completes normally.
- Counter wrap: CNT_W=2, 5 operations → op_count sequence 1,2,3,0,1.
